pc: RTL and testbench

PC -- requirements
Module: pc

---
 rtl/pc.sv | 32 +++
 tb/tb_pc.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pc.sv
// Program-counter register: a single WIDTH-bit flop that loads Pc_in on every
// rising edge and is forced to RESET_VALUE asynchronously while Rst is high.
module pc #(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Pc_in,
    output logic [WIDTH-1:0] Pc_out
);

    // Size cast truncates or zero-extends the 32-bit reset constant to WIDTH.
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // Pure pass-through: no increment, masking or alignment on the next value.
    assign pc_d = Pc_in;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pc_q <= RESET_W;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign Pc_out = pc_q;

endmodule

// File: tb/tb_pc.sv
// Directed bench for pc: a default 32-bit instance plus an 8-bit instance with a
// 9-bit reset constant to exercise truncation of RESET_VALUE.
module tb_pc;

    logic        Clk;
    logic        Rst;
    logic [31:0] Pc_in;
    logic [31:0] Pc_out;
    logic [7:0]  pc_in8;
    logic [7:0]  pc_out8;

    int tests_run;
    int tests_failed;

    pc dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Pc_in  (Pc_in),
        .Pc_out (Pc_out)
    );

    pc #(
        .WIDTH       (8),
        .RESET_VALUE (32'h0000_01A5)
    ) dut8 (
        .Clk    (Clk),
        .Rst    (Rst),
        .Pc_in  (pc_in8),
        .Pc_out (pc_out8)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
        $display("[TB] t=%0t %s observed=%h expected=%h", $time, tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset asserted from time zero, before any clock edge.
        Rst    = 1'b1;
        Pc_in  = 32'h1234_5678;
        pc_in8 = 8'h3C;
        #1;
        check("reset_async_32", Pc_out, 32'h0000_0000);
        check("reset_trunc_8", {24'h0, pc_out8}, 32'h0000_00A5);

        tick();
        check("reset_holds_edge_32", Pc_out, 32'h0000_0000);
        check("reset_holds_edge_8", {24'h0, pc_out8}, 32'h0000_00A5);

        // Deassert between edges: nothing loads until the next rising edge.
        @(negedge Clk);
        Rst   = 1'b0;
        Pc_in = 32'h0000_0000;
        #1;
        check("deassert_no_load_8", {24'h0, pc_out8}, 32'h0000_00A5);

        tick();
        check("first_edge_zero", Pc_out, 32'h0000_0000);
        check("first_edge_8", {24'h0, pc_out8}, 32'h0000_003C);

        Pc_in = 32'h0000_0001;
        #3;
        check("stable_before_edge", Pc_out, 32'h0000_0000);
        tick();
        check("load_one", Pc_out, 32'h0000_0001);

        Pc_in = 32'h0000_0002;
        #2;
        check("stable_mid_cycle", Pc_out, 32'h0000_0001);
        tick();
        check("load_two", Pc_out, 32'h0000_0002);

        // Mid-cycle reset with all-ones waiting on the input.
        #3;
        Pc_in  = 32'hFFFF_FFFF;
        pc_in8 = 8'hFF;
        Rst    = 1'b1;
        #1;
        check("reset_immediate", Pc_out, 32'h0000_0000);
        check("reset_immediate_8", {24'h0, pc_out8}, 32'h0000_00A5);
        tick();
        check("reset_ignores_in_1", Pc_out, 32'h0000_0000);
        tick();
        check("reset_ignores_in_2", Pc_out, 32'h0000_0000);

        #2;
        Pc_in = 32'hDEAD_BEEF;
        Rst   = 1'b0;
        #1;
        check("after_deassert_hold", Pc_out, 32'h0000_0000);
        tick();
        check("load_deadbeef", Pc_out, 32'hDEAD_BEEF);
        check("load_ff_8", {24'h0, pc_out8}, 32'h0000_00FF);

        Pc_in  = 32'hFFFF_FFFF;
        pc_in8 = 8'h00;
        tick();
        check("load_all_ones", Pc_out, 32'hFFFF_FFFF);
        check("load_zero_8", {24'h0, pc_out8}, 32'h0000_0000);
        Pc_in = 32'h0000_0000;
        tick();
        check("no_wrap_zero", Pc_out, 32'h0000_0000);

        Pc_in = 32'hAAAA_AAAA;
        tick();
        check("pattern_aa", Pc_out, 32'hAAAA_AAAA);
        Pc_in = 32'h5555_5555;
        tick();
        check("pattern_55", Pc_out, 32'h5555_5555);
        Pc_in = 32'h8000_0001;
        tick();
        check("pattern_msb_lsb", Pc_out, 32'h8000_0001);

        // Reset arriving at a rising edge wins over the load.
        Pc_in = 32'h1357_9BDF;
        @(posedge Clk);
        Rst = 1'b1;
        #1;
        check("reset_at_edge", Pc_out, 32'h0000_0000);
        @(negedge Clk);
        Rst = 1'b0;
        tick();
        check("load_after_edge_reset", Pc_out, 32'h1357_9BDF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
